seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 4-digit seven-segment display. It drives the select of the 4-to-1 8-bit segment-pattern mux and the active-low digit enables. It inserts a blanking interval on every digit change to suppress ghosting, and applies 16-level brightness by on-time slicing. It sits between the clock/time-formatting logic, which supplies the four segment bytes to the mux, and the display pins, and emits a frame strobe so upstream can update all four bytes atomically.

---
 rtl/seven_seg_pkg.sv | 16 +
 rtl/scan_tick_gen.sv | 31 +++
 rtl/seven_seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types for the seven-segment scan controller.
// Digit count, dark pattern, scan state and digit index.
package seven_seg_pkg;

    localparam int N_DIGITS = 4;
    localparam logic [3:0] DIGITS_DARK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    typedef logic [1:0] digit_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Loadable down-counter with clear; tc is high at count zero.
// Reloading on tc turns it into a one-cycle pulse per interval.
module scan_tick_gen #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] cnt;

    // Count down to zero and hold; load or clear take priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_tc = (cnt == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit seven-segment scan controller.
// Blanking between digits, 16-level on-time brightness.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int BLANK_TICKS = 4000,
    parameter int SUB_TICKS   = 6000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_bright,
    input  logic [3:0] i_blank_mask,
    output logic [1:0] o_sel,
    output logic [3:0] o_digit_n,
    output logic       o_frame
);

    localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
    localparam int SW = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
    localparam int CW = (BW > SW) ? BW : SW;
    localparam logic [CW-1:0] B_LOAD = CW'(BLANK_TICKS - 1);
    localparam logic [CW-1:0] S_LOAD = CW'(SUB_TICKS - 1);
    localparam digit_t LAST = digit_t'(N_DIGITS - 1);

    state_t        state_q, state_d;
    digit_t        sel_d;
    logic [3:0]    sub_q, sub_d;
    logic [3:0]    bright_q, mask_q;
    logic [3:0]    dn_d;
    logic          frame_d, latch;
    logic          cnt_clr, cnt_load, tc;
    logic [CW-1:0] load_val;

    scan_tick_gen #(.W(CW)) u_tick (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (cnt_clr),
        .i_load     (cnt_load),
        .i_load_val (load_val),
        .o_tc       (tc)
    );

    // Next state, slot sequencing and registered-output precompute.
    always_comb begin
        state_d  = state_q;
        sel_d    = o_sel;
        sub_d    = sub_q;
        frame_d  = 1'b0;
        latch    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        load_val = S_LOAD;
        if (!i_en) begin
            state_d = IDLE;
            sel_d   = '0;
            sub_d   = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    sel_d    = '0;
                    sub_d    = '0;
                    frame_d  = 1'b1;
                    latch    = 1'b1;
                    cnt_load = 1'b1;
                    load_val = B_LOAD;
                end
                BLANK: begin
                    if (tc) begin
                        state_d  = ON;
                        sub_d    = '0;
                        cnt_load = 1'b1;
                    end
                end
                ON: begin
                    if (tc) begin
                        cnt_load = 1'b1;
                        if (sub_q == 4'd15) begin
                            state_d  = BLANK;
                            sel_d    = o_sel + 2'd1;
                            sub_d    = '0;
                            frame_d  = (o_sel == LAST);
                            latch    = 1'b1;
                            load_val = B_LOAD;
                        end else begin
                            sub_d = sub_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    sub_d   = '0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
        dn_d = DIGITS_DARK;
        if (state_d == ON && sub_d <= bright_q && !mask_q[sel_d]) begin
            dn_d = ~(4'b0001 << sel_d);
        end
    end

    // State, outputs and per-slot latched settings.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            sub_q     <= '0;
            bright_q  <= '0;
            mask_q    <= '0;
            o_sel     <= '0;
            o_digit_n <= DIGITS_DARK;
            o_frame   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            o_sel     <= sel_d;
            o_digit_n <= dn_d;
            o_frame   <= frame_d;
            if (latch) begin
                bright_q <= i_bright;
                mask_q   <= i_blank_mask;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with an arithmetic timeline model.
// Expected outputs derive from cycles elapsed since enable.
module tb_seven_seg_scan_ctrl;

    localparam int B = 2;
    localparam int S = 1;
    localparam int L = B + 16 * S;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] bright;
    logic [3:0] mask;
    logic [1:0] sel;
    logic [3:0] dn;
    logic       frame;

    int tests = 0;
    int fails = 0;
    int t = -1;
    int lb = 0;
    logic [3:0] lm = 4'h0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .BLANK_TICKS (B),
        .SUB_TICKS   (S)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_bright     (bright),
        .i_blank_mask (mask),
        .o_sel        (sel),
        .o_digit_n    (dn),
        .o_frame      (frame)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic check_outputs();
        int slot, pos, d;
        logic [1:0] esel;
        logic [3:0] edn;
        logic       efr;
        esel = 2'd0;
        edn  = 4'hF;
        efr  = 1'b0;
        if (t >= 0) begin
            slot = t / L;
            pos  = t % L;
            d    = slot % 4;
            esel = 2'(d);
            efr  = (pos == 0) && (d == 0);
            if (pos >= B && ((pos - B) / S) <= lb && !lm[d])
                edn = ~(4'(1) << d);
        end
        check("sel", 32'(sel), 32'(esel));
        check("digit_n", 32'(dn), 32'(edn));
        check("frame", 32'(frame), 32'(efr));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst || !en) begin
            t = -1;
        end else begin
            t = (t < 0) ? 0 : (t + 1) % (4 * L);
            if (t % L == 0) begin
                lb = int'(bright);
                lm = mask;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_at(input int d, input int pos);
        bit hit;
        hit = 0;
        for (int i = 0; i < 6 * L && !hit; i++) begin
            if (t >= 0 && (t / L) % 4 == d && t % L == pos) hit = 1;
            else cycle();
        end
        check("reach_point", 32'(hit), 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        bright = 4'd15;
        mask   = 4'h0;
        #1;
        check_outputs();
        run(3);
        #1 rst = 1'b0;
        run(2);

        en = 1'b1;
        wait_at(2, B + 3);
        #1 rst = 1'b1;
        #1;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_digit_n", 32'(dn), 32'hF);
        check("rst_frame", 32'(frame), 32'd0);
        run(2);
        #1 rst = 1'b0;
        run(8 * L);

        bright = 4'd3;
        run(8 * L);

        mask = 4'b0100;
        run(5 * L);
        mask = 4'h0;
        bright = 4'd15;

        wait_at(1, 5);
        #1 bright = 4'd0;
        run(3 * L);

        bright = 4'd15;
        wait_at(3, B + 5);
        #1 en = 1'b0;
        run(4);
        #1 en = 1'b1;
        run(2 * L);

        for (int i = 0; i < 1500; i++) begin
            #1;
            if ($urandom_range(0, 9) == 0) bright = 4'($urandom);
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
            if ($urandom_range(0, 99) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
